note_scheduler: RTL

//  Monophonic key scheduler in front of the piano tone generator. Debounces seven

---
 rtl/note_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/note_scheduler.sv
// Monophonic key scheduler: debounces seven note keys and two octave buttons and
// arbitrates held keys onto one tone generator (last pressed wins, else lowest held).
module note_scheduler #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned OCT_DEFAULT     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] keys,
   input  logic       oct_up,
   input  logic       oct_down,
   output logic [2:0] octave,
   output logic [2:0] note,
   output logic       playing
);

   localparam int unsigned   CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [0:0]    StIdle = 1'b0;
   localparam logic [0:0]    StPlay = 1'b1;

   // Bits 0..6 are note keys, bit 7 is octave up, bit 8 is octave down.
   logic [8:0]      raw;
   logic [8:0]      sync1_q, sync2_q;
   logic [8:0]      smp_q, smp_d;
   logic [8:0]      stb_q, stb_d;
   logic [8:0]      stb_dly_q;
   logic [8:0]      rise, fall;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick;
   logic [1:0]      tcnt_q, tcnt_d;
   logic [6:0]      hold_q, hold_d;
   logic [0:0]      state_q, state_d;
   logic [2:0]      cur_q, cur_d;
   logic [2:0]      octave_q, octave_d;
   logic [2:0]      note_q, note_d;
   logic            playing_q, playing_d;
   logic [6:0]      key_rise, key_fall, key_held, cur_oh, other_rise, other_held;

   function automatic logic [2:0] lowest_idx(input logic [6:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = 6; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   assign raw  = {oct_down, oct_up, keys};
   assign tick = (cnt_q == CntMax);
   assign rise = stb_q & ~stb_dly_q;
   assign fall = ~stb_q & stb_dly_q;

   always_comb begin
      cnt_d  = tick ? '0 : cnt_q + 1'b1;
      smp_d  = smp_q;
      stb_d  = stb_q;
      tcnt_d = tcnt_q;
      if (tick) begin
         smp_d = sync2_q;
         stb_d = (~(smp_q ^ sync2_q) & sync2_q) | ((smp_q ^ sync2_q) & stb_q);
         if (tcnt_q != 2'd2) tcnt_d = tcnt_q + 2'd1;
      end
      // The second tick after reset is the first that can raise stb; anything it raises
      // was already held at reset release and stays masked until that key is let go.
      if (tick && tcnt_q == 2'd1) hold_d = stb_d[6:0];
      else                        hold_d = hold_q & stb_q[6:0];
   end

   always_comb begin
      octave_d = octave_q;
      if (rise[7] && !rise[8] && octave_q != 3'd7)      octave_d = octave_q + 3'd1;
      else if (rise[8] && !rise[7] && octave_q != 3'd0) octave_d = octave_q - 3'd1;
   end

   always_comb begin
      key_rise   = rise[6:0] & ~hold_q;
      key_fall   = fall[6:0] & ~hold_q;
      key_held   = stb_q[6:0] & ~hold_q;
      cur_oh     = 7'b1 << cur_q;
      other_rise = key_rise & ~cur_oh;
      other_held = key_held & ~cur_oh;
      state_d    = state_q;
      cur_d      = cur_q;
      if (state_q == StIdle) begin
         if (|key_rise) begin
            state_d = StPlay;
            cur_d   = lowest_idx(key_rise);
         end
      end else begin
         if (|other_rise) begin
            cur_d = lowest_idx(other_rise);
         end else if (|(key_fall & cur_oh)) begin
            if (|other_held) cur_d = lowest_idx(other_held);
            else             state_d = StIdle;
         end
      end
      playing_d = (state_d == StPlay);
      note_d    = playing_d ? cur_d + 3'd1 : 3'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         smp_q     <= '0;
         stb_q     <= '0;
         stb_dly_q <= '0;
         cnt_q     <= '0;
         tcnt_q    <= '0;
         hold_q    <= '0;
         state_q   <= StIdle;
         cur_q     <= '0;
         octave_q  <= 3'(OCT_DEFAULT);
         note_q    <= '0;
         playing_q <= 1'b0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         smp_q     <= smp_d;
         stb_q     <= stb_d;
         stb_dly_q <= stb_q;
         cnt_q     <= cnt_d;
         tcnt_q    <= tcnt_d;
         hold_q    <= hold_d;
         state_q   <= state_d;
         cur_q     <= cur_d;
         octave_q  <= octave_d;
         note_q    <= note_d;
         playing_q <= playing_d;
      end
   end

   assign octave  = octave_q;
   assign note    = note_q;
   assign playing = playing_q;

endmodule
